// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared types, state encoding and winner-select helper for the
//            DMA priority arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

   localparam int NUM_CH = 4;

   typedef logic [1:0] ch_idx_t;

   localparam logic [1:0] C_ST_IDLE     = 2'd0;
   localparam logic [1:0] C_ST_HOLD_REQ = 2'd1;
   localparam logic [1:0] C_ST_ACTIVE   = 2'd2;
   localparam logic [1:0] C_ST_RELEASE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = C_ST_IDLE,
      ST_HOLD_REQ = C_ST_HOLD_REQ,
      ST_ACTIVE   = C_ST_ACTIVE,
      ST_RELEASE  = C_ST_RELEASE
   } arb_state_t;

   // First requesting channel found when scanning upward from start (wraps).
   function automatic ch_idx_t pick_winner(input logic [NUM_CH-1:0] req,
                                           input ch_idx_t           start);
      ch_idx_t idx;
      ch_idx_t win;
      logic    found;
      win   = start;
      found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = start + ch_idx_t'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
      return win;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dma_dreq_sync.sv
`default_nettype none
// ============================================================================
// Module   : dma_dreq_sync
// Purpose  : Two-flop synchronizer for asynchronous DREQ lines followed by
//            the programmable request polarity correction.
// Revision : 1.0 - initial release
// ============================================================================
module dma_dreq_sync
   import dma_pkg::*;
#(
   parameter int WIDTH = NUM_CH
)
(
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DREQ,
   input  logic             DREQ_LOW,
   output logic [WIDTH-1:0] REQ_POL
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= DREQ;
         r_sync <= r_meta;
      end
   end

   assign REQ_POL = r_sync ^ {WIDTH{DREQ_LOW}};

endmodule
`default_nettype wire

// File: rtl/dma_priority_arb.sv
`default_nettype none
// ============================================================================
// Module   : dma_priority_arb
// Purpose  : 4-channel DMA request arbiter with HRQ/HLDA bus handshake,
//            fixed or rotating priority and programmable DREQ/DACK polarity.
//            Rotating priority exists only with DMA_ROTATING_PRIORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dma_priority_arb
   import dma_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic [3:0]  DREQ,
   input  logic        HLDA,
   input  logic [3:0]  MASK,
   input  logic        CMD_DISABLE,
   input  logic        CMD_ROT,
   input  logic        CMD_DREQ_LOW,
   input  logic        CMD_DACK_HIGH,
   input  logic        XFER_DONE,
   output logic        HRQ,
   output logic [3:0]  DACK,
   output logic [1:0]  ACT_CH,
   output logic        ACT_VALID
);

   logic [NUM_CH-1:0] w_req_pol;
   logic [NUM_CH-1:0] w_req;
   logic              w_any_req;
   logic              w_grant;
   logic              w_done;
   ch_idx_t           w_start;
   ch_idx_t           w_winner;
   logic [NUM_CH-1:0] w_grant_1hot;
   arb_state_t        w_state_next;

   arb_state_t        r_state;
   ch_idx_t           r_act_ch;
   logic [NUM_CH-1:0] r_dack;

   dma_dreq_sync #(.WIDTH(NUM_CH)) u_dreq_sync (
      .CLK      (CLK),
      .RESET    (RESET),
      .DREQ     (DREQ),
      .DREQ_LOW (CMD_DREQ_LOW),
      .REQ_POL  (w_req_pol)
   );

   assign w_req     = w_req_pol & ~MASK;
   assign w_any_req = |w_req;
   assign w_grant   = (r_state == ST_HOLD_REQ) && HLDA && w_any_req;
   assign w_done    = (r_state == ST_ACTIVE) && XFER_DONE;

`ifdef DMA_ROTATING_PRIORITY_EN
   ch_idx_t r_ptr;

   // Pointer moves only on a completed service; an aborted grant leaves it.
   always_ff @(posedge CLK) begin
      if (RESET)
         r_ptr <= '0;
      else if (w_done)
         r_ptr <= r_act_ch + 2'd1;
   end

   assign w_start = CMD_ROT ? r_ptr : '0;
`else
   logic w_unused_rot;
   assign w_unused_rot = CMD_ROT;
   assign w_start      = '0;
`endif

   assign w_winner     = pick_winner(w_req, w_start);
   assign w_grant_1hot = 4'b0001 << w_winner;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:
            if (w_any_req && !CMD_DISABLE)
               w_state_next = ST_HOLD_REQ;
         ST_HOLD_REQ:
            if (w_grant)
               w_state_next = ST_ACTIVE;
            else if (!w_any_req)
               w_state_next = ST_IDLE;
         ST_ACTIVE:
            if (XFER_DONE)
               w_state_next = ST_RELEASE;
            else if (!HLDA)
               w_state_next = ST_IDLE;
         ST_RELEASE:
            if (!HLDA)
               w_state_next = ST_IDLE;
         default:
            w_state_next = ST_IDLE;
      endcase
   end

   // DACK is registered with its polarity captured at grant time so nothing
   // on the command/mask inputs can disturb it while a channel is serviced.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state  <= ST_IDLE;
         r_act_ch <= '0;
         r_dack   <= '1;
      end else begin
         r_state <= w_state_next;
         if (w_grant) begin
            r_act_ch <= w_winner;
            r_dack   <= CMD_DACK_HIGH ? w_grant_1hot : ~w_grant_1hot;
         end else if (w_state_next != ST_ACTIVE) begin
            r_dack   <= {NUM_CH{~CMD_DACK_HIGH}};
         end
      end
   end

   assign HRQ       = (r_state == ST_HOLD_REQ) || (r_state == ST_ACTIVE);
   assign ACT_VALID = (r_state == ST_ACTIVE);
   assign ACT_CH    = r_act_ch;
   assign DACK      = r_dack;

endmodule
`default_nettype wire

// File: tb/tb_dma_priority_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_priority_arb
// Purpose  : Directed scoreboard bench for dma_priority_arb; grant checks are
//            queued by the stimulus and consumed by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_priority_arb;

   logic       CLK;
   logic       RESET;
   logic [3:0] DREQ;
   logic       HLDA;
   logic [3:0] MASK;
   logic       CMD_DISABLE;
   logic       CMD_ROT;
   logic       CMD_DREQ_LOW;
   logic       CMD_DACK_HIGH;
   logic       XFER_DONE;
   logic       HRQ;
   logic [3:0] DACK;
   logic [1:0] ACT_CH;
   logic       ACT_VALID;

   typedef struct packed {
      logic [1:0] ch;
      logic [3:0] dack;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_exp;
   logic mon_prev;
   int   n_checks;
   int   n_errors;

`ifdef DMA_ROTATING_PRIORITY_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   dma_priority_arb u_dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .DREQ          (DREQ),
      .HLDA          (HLDA),
      .MASK          (MASK),
      .CMD_DISABLE   (CMD_DISABLE),
      .CMD_ROT       (CMD_ROT),
      .CMD_DREQ_LOW  (CMD_DREQ_LOW),
      .CMD_DACK_HIGH (CMD_DACK_HIGH),
      .XFER_DONE     (XFER_DONE),
      .HRQ           (HRQ),
      .DACK          (DACK),
      .ACT_CH        (ACT_CH),
      .ACT_VALID     (ACT_VALID)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RESET = 1'b1;  DREQ = 4'b0000; HLDA = 1'b0; MASK = 4'b0000;
      CMD_DISABLE = 1'b0; CMD_ROT = 1'b0; CMD_DREQ_LOW = 1'b0;
      CMD_DACK_HIGH = 1'b0; XFER_DONE = 1'b0;
      step();
      step();
      chk("rst_hrq",   HRQ,       1'b0);
      chk("rst_valid", ACT_VALID, 1'b0);
      chk("rst_ch",    ACT_CH,    2'd0);
      chk("rst_dack",  DACK,      4'b1111);
      RESET = 1'b0;
   endtask

   task automatic wait_hrq(input int budget);
      int n;
      n = 0;
      while (!HRQ && n < budget) begin
         step();
         n++;
      end
      chk("hrq_wait", HRQ, 1'b1);
   endtask

   // One full service: hold acknowledge, grant, transfer done, bus return.
   task automatic serve(input logic [1:0] ch, input logic [3:0] dack_act);
      logic [3:0] idle_lvl;
      wait_hrq(12);
      HLDA = 1'b1;
      exp_q.push_back(exp_t'({ch, dack_act}));
      step();
      step();
      XFER_DONE = 1'b1;
      step();
      XFER_DONE = 1'b0;
      idle_lvl = {4{~CMD_DACK_HIGH}};
      chk("rel_hrq",   HRQ,       1'b0);
      chk("rel_valid", ACT_VALID, 1'b0);
      chk("rel_dack",  DACK,      idle_lvl);
      HLDA = 1'b0;
      step();
   endtask

   // Grant monitor: every rising ACT_VALID must match the oldest expectation.
   initial begin
      mon_prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            mon_prev = 1'b0;
         end else begin
            if (ACT_VALID && !mon_prev) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL grant_unexpected: got ch=%0d dack=%b, required no grant", ACT_CH, DACK);
               end else begin
                  mon_exp = exp_q.pop_front();
                  chk("grant_ch",   ACT_CH, mon_exp.ch);
                  chk("grant_dack", DACK,   mon_exp.dack);
               end
            end
            mon_prev = ACT_VALID;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;

      // Single channel 2 request: latency and frozen grant.
      apply_reset();
      DREQ = 4'b0100;
      step();
      step();
      chk("hrq_lat2", HRQ, 1'b0);
      step();
      chk("hrq_lat3", HRQ, 1'b1);
      step();
      step();
      chk("hrq_hold", HRQ, 1'b1);
      HLDA = 1'b1;
      exp_q.push_back(exp_t'({2'd2, 4'b1011}));
      step();
      MASK = 4'b1111;
      DREQ = 4'b0000;
      step();
      chk("dack_frozen", DACK, 4'b1011);
      chk("ch_frozen",   ACT_CH, 2'd2);
      XFER_DONE = 1'b1;
      step();
      XFER_DONE = 1'b0;
      chk("done_dack",  DACK,      4'b1111);
      chk("done_hrq",   HRQ,       1'b0);
      chk("done_valid", ACT_VALID, 1'b0);
      HLDA = 1'b0;
      step();

      // Fixed priority: channel 0 always wins.
      apply_reset();
      DREQ = 4'b1111;
      for (int i = 0; i < 3; i++)
         serve(2'd0, 4'b1110);

      // Rotating priority (fixed when the option is absent).
      apply_reset();
      CMD_ROT = 1'b1;
      DREQ = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         logic [1:0] ch;
         logic [3:0] dk;
         ch = ROT_EN ? 2'(i % 4) : 2'd0;
         dk = ~(4'b0001 << ch);
         serve(ch, dk);
      end

      // Masked request, then unmask.
      apply_reset();
      MASK = 4'b0001;
      DREQ = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("mask_nohrq", HRQ, 1'b0);
      end
      MASK = 4'b0000;
      step();
      chk("unmask_hrq", HRQ, 1'b1);
      serve(2'd0, 4'b1110);

      // Controller disabled blocks new requests.
      apply_reset();
      CMD_DISABLE = 1'b1;
      DREQ = 4'b0001;
      for (int i = 0; i < 5; i++) step();
      chk("dis_nohrq", HRQ, 1'b0);
      CMD_DISABLE = 1'b0;
      step();
      chk("enable_hrq", HRQ, 1'b1);

      // Bus reclaimed mid-grant on channel 1, pointer must not advance.
      apply_reset();
      CMD_ROT = 1'b1;
      DREQ = 4'b0010;
      wait_hrq(12);
      HLDA = 1'b1;
      exp_q.push_back(exp_t'({2'd1, 4'b1101}));
      step();
      chk("abort_pre_valid", ACT_VALID, 1'b1);
      HLDA = 1'b0;
      step();
      chk("abort_dack",  DACK,      4'b1111);
      chk("abort_valid", ACT_VALID, 1'b0);
      chk("abort_hrq",   HRQ,       1'b0);
      DREQ = 4'b1111;
      step();
      step();
      step();
      serve(2'd0, 4'b1110);
      step();
      chk("rst_mid_pre_hrq", HRQ, 1'b1);
      RESET = 1'b1;
      DREQ = 4'b0000;
      step();
      chk("rst_mid_hrq", HRQ, 1'b0);
      RESET = 1'b0;
      step();

      // Inverted polarities: active-low DREQ, active-high DACK.
      apply_reset();
      CMD_DACK_HIGH = 1'b1;
      CMD_DREQ_LOW = 1'b1;
      DREQ = 4'b1110;
      step();
      step();
      step();
      serve(2'd0, 4'b0001);

      apply_reset();
      step();
      chk("sb_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dma_priority_arb.md
DMA_PRIORITY_ARB -- requirements
Module: dma_priority_arb

Interface
REQ-001 The clock and reset SHALL be one clock (CLK) and one synchronous, active-high reset (RESET); all state SHALL change only on the CLK rising edge.
REQ-002 CLK  in  1  system clock.
REQ-003 RESET  in  1  synchronous active-high reset.
REQ-004 DREQ  in  4  asynchronous per-channel DMA requests.
REQ-005 HLDA  in  1  hold acknowledge from the CPU.
REQ-006 MASK  in  4  per-channel mask from the datapath; 1 = masked.
REQ-007 CMD_DISABLE  in  1  command register bit 2; 1 = controller disabled.
REQ-008 CMD_ROT  in  1  command register bit 4; 1 = rotating priority.
REQ-009 CMD_DREQ_LOW  in  1  command register bit 6; 1 = DREQ active-low.
REQ-010 CMD_DACK_HIGH  in  1  command register bit 7; 1 = DACK active-high.
REQ-011 XFER_DONE  in  1  one-cycle pulse from timing control marking end of service (single transfer complete, TC, or EOP).
REQ-012 HRQ  out  1  hold request to the CPU.
REQ-013 DACK  out  4  per-channel acknowledge, polarity per CMD_DACK_HIGH.
REQ-014 ACT_CH  out  2  index of the channel being serviced.
REQ-015 ACT_VALID  out  1  1 while a grant is held (ACTIVE state).

Function
REQ-016 DREQ SHALL pass a 2-flop synchronizer; effective req[i] = (sync_dreq[i] XOR CMD_DREQ_LOW) AND NOT MASK[i].
REQ-017 The FSM SHALL have the states IDLE, HOLD_REQ, ACTIVE and RELEASE.
REQ-018 IDLE: when any req is set and CMD_DISABLE=0, the FSM SHALL go to HOLD_REQ, and HRQ SHALL be 1 on the next cycle (3 cycles from a DREQ edge to HRQ).
REQ-019 HOLD_REQ: HRQ SHALL be 1; if all req drop before HLDA=1, the FSM SHALL go to IDLE and HRQ SHALL drop.
REQ-020 HOLD_REQ with HLDA=1: the arbiter SHALL select the winner among the current req, and the FSM SHALL go to ACTIVE; DACK[winner], ACT_CH and ACT_VALID SHALL be valid on the next cycle.
REQ-021 Fixed priority (CMD_ROT=0): channel 0 highest, channel 3 lowest.
REQ-022 Rotating priority (CMD_ROT=1): a 2-bit pointer SHALL name the highest-priority channel; on XFER_DONE it SHALL become (serviced channel + 1) mod 4, wrapping 3 to 0.
REQ-023 ACTIVE: the grant SHALL be frozen; there SHALL be no preemption by higher requests, and MASK, CMD_* or DREQ changes SHALL not alter DACK.
REQ-024 ACTIVE with XFER_DONE=1: the FSM SHALL go to RELEASE; HRQ SHALL drop, DACK SHALL go inactive and ACT_VALID SHALL be 0 on the next cycle.
REQ-025 ACTIVE with HLDA=0 (bus reclaimed, no XFER_DONE): the FSM SHALL abort to IDLE, DACK SHALL go inactive next cycle, and the pointer SHALL remain unchanged.
REQ-026 Simultaneous XFER_DONE and HLDA=0: XFER_DONE SHALL take precedence (pointer updated); the FSM SHALL go to RELEASE, then to IDLE on the following cycle.
REQ-027 RELEASE: the FSM SHALL stay until HLDA=0, then go to IDLE; no new HRQ SHALL be raised while HLDA=1.
REQ-028 CMD_DISABLE=1 SHALL block only IDLE to HOLD_REQ; a service in progress SHALL complete normally.
REQ-029 The inactive DACK level SHALL be NOT CMD_DACK_HIGH; the active level SHALL be CMD_DACK_HIGH.

Reset
REQ-030 On RESET=1 the block SHALL enter IDLE with HRQ=0, ACT_VALID=0, ACT_CH=0, pointer=0, synchronizers cleared and DACK=4'b1111 (default active-low, inactive); a RESET mid-ACTIVE SHALL take effect on the next edge.

Configuration
REQ-031 Macro DMA_ROTATING_PRIORITY_EN: when defined, REQ-022 SHALL be implemented; when undefined, the pointer logic SHALL be absent, CMD_ROT SHALL be ignored, and fixed priority SHALL always apply.

Structure
REQ-032 Package dma_pkg SHALL hold: NUM_CH=4, typedef ch_idx_t (2-bit), typedef arb_state_t (enum of the four states).
REQ-033 Sub-module dma_dreq_sync SHALL implement the 2-flop synchronizer plus the polarity XOR; the FSM and arbiter SHALL remain in dma_priority_arb.

Verification
REQ-034 The bench SHALL drive DREQ=4'b0100 with default CMD and HLDA raised 2 cycles after HRQ -> HRQ at cycle 3, DACK=4'b1011, ACT_CH=2; XFER_DONE -> DACK=4'b1111 and HRQ=0.
REQ-035 The bench SHALL drive DREQ=4'b1111 under fixed priority through three services -> ACT_CH=0 each time.
REQ-036 The bench SHALL drive DREQ=4'b1111 with CMD_ROT=1 and the macro defined -> ACT_CH sequence 0,1,2,3,0.
REQ-037 The bench SHALL drive DREQ=4'b0001 with MASK=4'b0001, then MASK=0 -> no HRQ while masked, HRQ 1 cycle after unmask.
REQ-038 The bench SHALL apply HLDA=0 during ACTIVE on channel 1 -> IDLE, DACK inactive next cycle, pointer unchanged; then RESET mid-HOLD_REQ -> HRQ=0 next cycle.
REQ-039 The bench SHALL set CMD_DACK_HIGH=1 and CMD_DREQ_LOW=1 with DREQ=4'b1110 -> channel 0 granted, DACK=4'b0001.
